// File: rtl/trellis_bank_sched_if.sv
// Bus bundle between the ACS stage / decoder datapath and the trellis bank scheduler.
// The datapath drives enable and sel_i (master); the scheduler drives the memory and TBU controls (slave).
interface trellis_bank_sched_if #(
  parameter int ADDR_W = 10,
  parameter int SEL_W  = 8
);
  logic                  enable;
  logic [SEL_W-1:0]      sel_i;
  logic [3:0]            mem_wr_o;
  logic [4*ADDR_W-1:0]   mem_addr_o;
  logic [SEL_W-1:0]      mem_d_o;
  logic [1:0]            tbu_en_o;
  logic [1:0]            tbu_bank_o;
  logic                  disp_bank_o;
  logic                  busy_o;
  logic [1:0]            state_o;

  modport master (
    output enable, sel_i,
    input  mem_wr_o, mem_addr_o, mem_d_o, tbu_en_o, tbu_bank_o,
           disp_bank_o, busy_o, state_o
  );

  modport slave (
    input  enable, sel_i,
    output mem_wr_o, mem_addr_o, mem_d_o, tbu_en_o, tbu_bank_o,
           disp_bank_o, busy_o, state_o
  );
endinterface

// File: rtl/trellis_bank_sched.sv
// Four-bank trellis memory sequencer with trace-back unit enables and routing selects.
// Optional macro TRELLIS_SCHED_DRAIN_EN adds a DRAIN state that lets the TBUs finish after enable drops.
module trellis_bank_sched #(
  parameter int ADDR_W = 10,
  parameter int SEL_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  trellis_bank_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   wr_cnt_reg, wr_cnt_next;
  logic [ADDR_W-1:0]   rd_cnt;
  logic [1:0]          bank_reg, bank_next;
  logic [1:0]          bank_d1_reg;
  logic [1:0]          tbu_bank_reg;
  logic [1:0]          tbu_en_reg, tbu_en_next;
  logic                disp_bank_reg;
  logic [SEL_W-1:0]    mem_d_reg;
  logic                advance;
  logic                write_ok;
  logic                wrap;
`ifdef TRELLIS_SCHED_DRAIN_EN
  logic                drain_wrap_reg, drain_wrap_next;
`endif

  // The read counter is by construction the bitwise complement of the write counter.
  assign rd_cnt = ~wr_cnt_reg;
  assign wrap   = advance && (wr_cnt_reg == {ADDR_W{1'b1}});

  always_comb begin
`ifdef TRELLIS_SCHED_DRAIN_EN
    // Leaving RUN with enable low still advances: that edge is the first DRAIN step.
    advance  = bus.enable || (state_reg == RUN) || (state_reg == DRAIN);
    write_ok = bus.enable && (state_reg != DRAIN);
`else
    advance  = bus.enable;
    write_ok = bus.enable;
`endif
  end

  always_comb begin
    wr_cnt_next = '0;
    bank_next   = bank_reg;
    if (advance) begin
      wr_cnt_next = wr_cnt_reg + 1'b1;
      if (wrap)
        bank_next = bank_reg + 2'd1;
    end
  end

  assign tbu_en_next = tbu_en_reg | {bank_d1_reg == 2'd3, bank_d1_reg == 2'd2};

  always_comb begin
    state_next = state_reg;
`ifdef TRELLIS_SCHED_DRAIN_EN
    drain_wrap_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.enable)
          state_next = FILL;
      end
      FILL: begin
        if (!bus.enable)
          state_next = IDLE;
        else if (tbu_en_next[0])
          state_next = RUN;
      end
      RUN: begin
        if (!bus.enable) begin
`ifdef TRELLIS_SCHED_DRAIN_EN
          state_next = DRAIN;
`else
          state_next = IDLE;
`endif
        end
      end
      DRAIN: begin
`ifdef TRELLIS_SCHED_DRAIN_EN
        // Second bank wrap inside DRAIN ends it; the counters wrap to 0 on that same edge.
        drain_wrap_next = drain_wrap_reg | wrap;
        if (wrap && drain_wrap_reg) begin
          state_next      = IDLE;
          drain_wrap_next = 1'b0;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wr_cnt_reg    <= '0;
      bank_reg      <= 2'd0;
      bank_d1_reg   <= 2'd0;
      tbu_bank_reg  <= 2'd0;
      tbu_en_reg    <= 2'b00;
      disp_bank_reg <= 1'b0;
      mem_d_reg     <= '0;
`ifdef TRELLIS_SCHED_DRAIN_EN
      drain_wrap_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      wr_cnt_reg    <= wr_cnt_next;
      bank_reg      <= bank_next;
      bank_d1_reg   <= bank_reg;
      tbu_bank_reg  <= bank_d1_reg;
      tbu_en_reg    <= tbu_en_next;
      disp_bank_reg <= tbu_bank_reg[0];
      mem_d_reg     <= bus.sel_i;
`ifdef TRELLIS_SCHED_DRAIN_EN
      drain_wrap_reg <= drain_wrap_next;
`endif
    end
  end

  // Per-bank port: role follows the bank's distance from the current write bank.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [1:0]        rel;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              wr_reg;

    assign rel = 2'(gi) - bank_reg;

    always_comb begin
      case (rel)
        2'd0:    addr_next = wr_cnt_reg;
        2'd2:    addr_next = '0;
        default: addr_next = rd_cnt;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        addr_reg <= '0;
        wr_reg   <= 1'b0;
      end else begin
        addr_reg <= addr_next;
        wr_reg   <= write_ok && (rel == 2'd0);
      end
    end

    assign bus.mem_addr_o[gi*ADDR_W +: ADDR_W] = addr_reg;
    assign bus.mem_wr_o[gi]                    = wr_reg;
  end

  assign bus.mem_d_o     = mem_d_reg;
  assign bus.tbu_en_o    = tbu_en_reg;
  assign bus.tbu_bank_o  = tbu_bank_reg;
  assign bus.disp_bank_o = disp_bank_reg;
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.state_o     = state_reg;

endmodule
